// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx, the receive FIFO and its consumer.
// With UART_RX_FIFO_OVF_EN defined, the bundle also carries ovf and ovf_clr.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    in_data;
  logic          in_stb;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          full;
  logic [CW-1:0] count;

`ifdef UART_RX_FIFO_OVF_EN
  logic ovf;
  logic ovf_clr;

  modport slave (
    input  in_data, in_stb, out_ready, ovf_clr,
    output out_data, out_valid, full, count, ovf
  );

  modport master (
    output in_data, in_stb, out_ready, ovf_clr,
    input  out_data, out_valid, full, count, ovf
  );
`else
  modport slave (
    input  in_data, in_stb, out_ready,
    output out_data, out_valid, full, count
  );

  modport master (
    output in_data, in_stb, out_ready,
    input  out_data, out_valid, full, count
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_rx: captures on the strobe's rising edge, FWFT output.
// Define UART_RX_FIFO_OVF_EN for the sticky overflow flag (ovf/ovf_clr).
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          stb_q;
  logic          push_req;
  logic          pop;
  logic          push;
  logic          full;
  logic          valid;

  assign full     = (cnt == FULL_CNT);
  assign valid    = (cnt != '0);
  assign push_req = bus.in_stb & ~stb_q;
  assign pop      = valid & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);

  assign bus.full      = full;
  assign bus.count     = cnt;
  assign bus.out_valid = valid;
  assign bus.out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      stb_q  <= 1'b0;
    end else begin
      stb_q <= bus.in_stb;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= bus.in_data;
  end

`ifdef UART_RX_FIFO_OVF_EN
  logic drop;
  logic ovf_q;

  assign drop    = push_req & full & ~pop;
  assign bus.ovf = ovf_q;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (bus.ovf_clr)
      ovf_q <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed strobes feed an expected-byte
// queue; a negedge monitor checks every accepted output byte in order.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(16)) bus ();

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready now.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          miscompares++;
          $display("FAIL out_data: got %0h expected %0h", bus.out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe held for n cycles, then one low cycle so the next edge is fresh.
  task automatic send(input logic [7:0] d, input int n, input bit accept);
    bus.in_data = d;
    bus.in_stb  = 1'b1;
    if (accept)
      exp_q.push_back(d);
    repeat (n) tick();
    bus.in_stb = 1'b0;
    tick();
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    bus.out_ready = 1'b0;
    chk("drain_timeout", budget > 0, 1);
  endtask

  initial begin
    int maxcnt;
    rst           = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_stb    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef UART_RX_FIFO_OVF_EN
    bus.ovf_clr   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_full", int'(bus.full), 0);

    // Single byte, one-cycle latency.
    bus.in_data = 8'hA5;
    bus.in_stb  = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    bus.in_stb = 1'b0;
    chk("a5_valid", int'(bus.out_valid), 1);
    chk("a5_data", int'(bus.out_data), 8'hA5);
    chk("a5_count", int'(bus.count), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("a5_pop_count", int'(bus.count), 0);
    chk("a5_pop_valid", int'(bus.out_valid), 0);

    // Long strobe gives one entry.
    send(8'h3C, 5, 1'b1);
    chk("long_stb_count", int'(bus.count), 1);
    drain();

    // Fill, then overflow.
    for (int i = 0; i < 16; i++)
      send(8'(i), 1, 1'b1);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_count", int'(bus.count), 16);
    send(8'hFF, 1, 1'b0);
    chk("drop_count", int'(bus.count), 16);
`ifdef UART_RX_FIFO_OVF_EN
    chk("ovf_set", int'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    send(8'hFE, 1, 1'b0);
    chk("ovf_drop_wins", int'(bus.ovf), 1);
`endif
    drain();
    chk("drain_count", int'(bus.count), 0);
`ifdef UART_RX_FIFO_OVF_EN
    tick();
    chk("ovf_clr", int'(bus.ovf), 0);
    bus.ovf_clr = 1'b0;
`endif

    // Full + same-cycle push and pop; 0x77 must come out last.
    for (int i = 0; i < 16; i++)
      send(8'h10 + 8'(i), 1, 1'b1);
    bus.in_data   = 8'h77;
    bus.in_stb    = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    bus.in_stb    = 1'b0;
    bus.out_ready = 1'b0;
    chk("pushpop_count", int'(bus.count), 16);
`ifdef UART_RX_FIFO_OVF_EN
    chk("pushpop_no_ovf", int'(bus.ovf), 0);
`endif
    tick();
    drain();
    chk("wrap_empty", int'(bus.count), 0);

    // Streaming with consumer always ready.
    maxcnt = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.in_data = 8'h40 + 8'(i);
      bus.in_stb  = 1'b1;
      exp_q.push_back(bus.in_data);
      for (int c = 0; c < 3; c++) begin
        tick();
        bus.in_stb = 1'b0;
        if (int'(bus.count) > maxcnt)
          maxcnt = int'(bus.count);
      end
    end
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("stream_left", exp_q.size(), 0);
    chk("stream_maxcnt", maxcnt, 1);

    // Reset with 5 stored bytes; strobe high through reset.
    for (int i = 0; i < 5; i++)
      send(8'h60 + 8'(i), 1, 1'b1);
    chk("pre_rst_count", int'(bus.count), 5);
    rst         = 1'b1;
    bus.in_data = 8'hE7;
    bus.in_stb  = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_full", int'(bus.full), 0);
`ifdef UART_RX_FIFO_OVF_EN
    chk("mid_rst_ovf", int'(bus.ovf), 0);
`endif
    exp_q.push_back(8'hE7);
    tick();
    bus.in_stb = 1'b0;
    chk("post_rst_count", int'(bus.count), 1);
    chk("post_rst_data", int'(bus.out_data), 8'hE7);
    drain();
    chk("final_count", int'(bus.count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
